// File: rtl/regb_fifo_pkt_reader_pkg.sv
// ----------------------------------------------------------------------------
// regb_fifo_pkt_reader_pkg : shared FSM encoding and width default.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regb_fifo_pkt_reader_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    S_HEADER  = 1'b0,
    S_PAYLOAD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regb_fifo_pkt_reader_if.sv
// ----------------------------------------------------------------------------
// regb_fifo_pkt_reader_if : FIFO head + payload stream bundle.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regb_fifo_pkt_reader_if
  import regb_fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] fifo_data;
  logic             fifo_empty_n;
  logic             fifo_shift_out;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_sop;
  logic             m_eop;

  modport master (
    input  fifo_data, fifo_empty_n, m_ready,
    output fifo_shift_out, m_data, m_valid, m_sop, m_eop
  );

  modport slave (
    output fifo_data, fifo_empty_n, m_ready,
    input  fifo_shift_out, m_data, m_valid, m_sop, m_eop
  );

endinterface

`default_nettype wire

// File: rtl/regb_out_slot.sv
// ----------------------------------------------------------------------------
// regb_out_slot : single-entry output register with valid/ready.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regb_out_slot
  import regb_fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_sop,
  input  logic             load_eop,
  input  logic             ready,
  output logic             free,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             sop,
  output logic             eop
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;

  // A load in the accept cycle simply overwrites the slot: no bubble.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
      sop_d   = load_sop;
      eop_d   = load_eop;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign free  = ~valid_q | ready;
  assign data  = data_q;
  assign valid = valid_q;
  assign sop   = sop_q;
  assign eop   = eop_q;

endmodule

`default_nettype wire

// File: rtl/regb_fifo_pkt_reader.sv
// ----------------------------------------------------------------------------
// regb_fifo_pkt_reader : strips length headers from a FIFO stream.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regb_fifo_pkt_reader
  import regb_fifo_pkt_reader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   res,
  regb_fifo_pkt_reader_if.master bus,
  output logic                   busy,
  output logic                   err_zero_len,
  output logic                   pkt_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic             err_zero_len_q, err_zero_len_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pop;
  logic             payload_pop;
  logic             slot_free;
  logic             last_word;

  assign last_word = (rem_q == WIDTH'(1));

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    first_d        = first_q;
    pop            = 1'b0;
    payload_pop    = 1'b0;
    err_zero_len_d = 1'b0;
    pkt_done_d     = bus.m_valid & bus.m_ready & bus.m_eop;
    case (state_q)
      S_HEADER: begin
        // Headers never touch the output slot, so a stalled eop word
        // does not block the next header pop.
        pop = bus.fifo_empty_n;
        if (pop) begin
          if (bus.fifo_data != '0) begin
            rem_d   = bus.fifo_data;
            first_d = 1'b1;
            state_d = S_PAYLOAD;
          end else begin
            err_zero_len_d = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        pop         = bus.fifo_empty_n & slot_free;
        payload_pop = pop;
        if (pop) begin
          first_d = 1'b0;
          rem_d   = rem_q - 1'b1;
          if (last_word) begin
            state_d = S_HEADER;
          end
        end
      end
      default: state_d = S_HEADER;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q        <= S_HEADER;
      rem_q          <= '0;
      first_q        <= 1'b0;
      err_zero_len_q <= 1'b0;
      pkt_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      first_q        <= first_d;
      err_zero_len_q <= err_zero_len_d;
      pkt_done_q     <= pkt_done_d;
    end
  end

  regb_out_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk       (clk),
    .res       (res),
    .load      (payload_pop),
    .load_data (bus.fifo_data),
    .load_sop  (first_q),
    .load_eop  (last_word),
    .ready     (bus.m_ready),
    .free      (slot_free),
    .data      (bus.m_data),
    .valid     (bus.m_valid),
    .sop       (bus.m_sop),
    .eop       (bus.m_eop)
  );

  assign bus.fifo_shift_out = pop & ~res;
  assign busy               = (state_q == S_PAYLOAD);
  assign err_zero_len       = err_zero_len_q;
  assign pkt_done           = pkt_done_q;

endmodule

`default_nettype wire
